// File: rtl/board_buttons_if.sv
// Front-panel button bundle: raw active-low pins in, debounced levels,
// edge/long-press strobes and the image-select index out.
interface board_buttons_if #(
  parameter int NUM_BUTTONS = 2,
  parameter int IMG_W       = 2
);
  logic [NUM_BUTTONS-1:0] buttons_n;
  logic [NUM_BUTTONS-1:0] pressed;
  logic [NUM_BUTTONS-1:0] press_pulse;
  logic [NUM_BUTTONS-1:0] release_pulse;
  logic [NUM_BUTTONS-1:0] long_pulse;
  logic [IMG_W-1:0]       image_select;

  modport master (
    output buttons_n,
    input  pressed, press_pulse, release_pulse, long_pulse, image_select
  );

  modport slave (
    input  buttons_n,
    output pressed, press_pulse, release_pulse, long_pulse, image_select
  );
endinterface

// File: rtl/board_buttons.sv
// Synchronises and debounces active-low front-panel buttons, raises press,
// release and long-press strobes, and steps the image-select register.
module board_buttons #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 251750,
  parameter int LONG_PRESS_CYCLES = 25175000,
  parameter int NUM_IMAGES        = 4,
  parameter int SELECT_BUTTON     = 1,
  parameter int IMAGE_RESET       = 0
) (
  input  logic             clk_25_175,
  input  logic             rst,
  board_buttons_if.slave   bus
);
  localparam int IMG_W  = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1;
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_FULL = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [IMG_W-1:0]  IMG_LAST  = IMG_W'(NUM_IMAGES - 1);
  localparam logic [IMG_W-1:0]  IMG_INIT  = IMG_W'(IMAGE_RESET);

  typedef enum logic [1:0] {IDLE, HELD, LONG} sel_state_t;

  logic [NUM_BUTTONS-1:0] sync1, sync2, level, stable;
  logic [NUM_BUTTONS-1:0] pressed_q, press_q, release_q, long_q, long_seen;
  logic [DB_W-1:0]        db_cnt   [NUM_BUTTONS];
  logic [HOLD_W-1:0]      hold_cnt [NUM_BUTTONS];

  sel_state_t       state, state_next;
  logic [IMG_W-1:0] image_q, image_next;

  assign level = ~sync2;

  // The stable state only flips after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; the hold counter saturates so long_pulse never repeats.
  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      sync1     <= '1;
      sync2     <= '1;
      stable    <= '0;
      pressed_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      long_seen <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync1     <= bus.buttons_n;
      sync2     <= sync1;
      pressed_q <= stable;
      press_q   <= stable & ~pressed_q;
      release_q <= ~stable & pressed_q;
      long_q    <= '0;
      long_seen <= (long_seen | long_q) & ~release_q;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (level[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end

        if (!pressed_q[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] == HOLD_LAST && !long_seen[i]) begin
          long_q[i]   <= 1'b1;
          hold_cnt[i] <= HOLD_FULL;
        end else if (hold_cnt[i] < HOLD_LAST) begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (rst) begin
      state   <= IDLE;
      image_q <= IMG_INIT;
    end else begin
      state   <= state_next;
      image_q <= image_next;
    end
  end

  // A long press that coincides with the release still resets the image.
  always_comb begin
    state_next = state;
    image_next = image_q;
    case (state)
      IDLE: begin
        if (press_q[SELECT_BUTTON]) state_next = HELD;
      end
      HELD: begin
        if (long_q[SELECT_BUTTON]) begin
          image_next = '0;
          state_next = release_q[SELECT_BUTTON] ? IDLE : LONG;
        end else if (release_q[SELECT_BUTTON]) begin
          state_next = IDLE;
          image_next = (image_q == IMG_LAST) ? '0 : image_q + 1'b1;
        end
      end
      LONG: begin
        if (release_q[SELECT_BUTTON]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.pressed       = pressed_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.image_select  = image_q;
endmodule

// File: tb/tb_board_buttons.sv
// Self-checking bench for board_buttons: directed table, hand-written timing
// sequences and randomized pins against a sample-history reference model.
module tb_board_buttons;
  localparam int NB = 2;
  localparam int DB = 4;
  localparam int LP = 20;
  localparam int NI = 3;
  localparam int SEL = 1;
  localparam int IR = 0;
  localparam int IW = 2;
  localparam int MAXE = 20000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  board_buttons_if #(.NUM_BUTTONS(NB), .IMG_W(IW)) bus();

  board_buttons #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DB), .LONG_PRESS_CYCLES(LP),
    .NUM_IMAGES(NI), .SELECT_BUTTON(SEL), .IMAGE_RESET(IR)
  ) dut (
    .clk_25_175(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, bus.pressed, bus.press_pulse, bus.release_pulse, bus.long_pulse, bus.image_select};
  endfunction

  // Reference model: per-edge histories of sampled pin levels and debounced
  // levels; a flip needs DB consecutive disagreeing samples, a long press is
  // a run of exactly LP held cycles.
  bit [NB-1:0] samp_h [0:MAXE];
  bit [NB-1:0] stab_h [0:MAXE];
  bit [NB-1:0] pr_h   [0:MAXE];
  bit [NB-1:0] rel_h  [0:MAXE];
  bit [NB-1:0] long_h [0:MAXE];
  int ec = 32;
  logic [NB-1:0] exp_pressed, exp_press, exp_release, exp_long;
  logic [IW-1:0] exp_img;
  bit long_mode = 1'b0;
  bit model_ready = 1'b0;

  always @(posedge clk) begin : model
    bit cur, all_diff, run;
    ec++;
    if (ec >= MAXE) begin
      $display("[TB] FAIL model_capacity actual=%0d required=<%0d", ec, MAXE);
      $fatal(1, "[TB] model history exhausted");
    end
    if (rst) begin
      samp_h[ec] = '0; stab_h[ec] = '0; pr_h[ec] = '0; rel_h[ec] = '0; long_h[ec] = '0;
      exp_pressed = '0; exp_press = '0; exp_release = '0; exp_long = '0;
      exp_img = IW'(IR);
      long_mode = 1'b0;
    end else begin
      if (long_h[ec-1][SEL]) begin
        exp_img = '0;
        long_mode = !rel_h[ec-1][SEL];
      end else if (rel_h[ec-1][SEL]) begin
        if (!long_mode) exp_img = IW'((int'(exp_img) + 1) % NI);
        long_mode = 1'b0;
      end
      samp_h[ec] = ~bus.buttons_n;
      for (int b = 0; b < NB; b++) begin
        cur = stab_h[ec-1][b];
        all_diff = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (samp_h[ec-j][b] == cur) all_diff = 1'b0;
        stab_h[ec][b] = all_diff ? ~cur : cur;
        run = 1'b1;
        for (int j = 1; j <= LP; j++)
          if (!pr_h[ec-j][b]) run = 1'b0;
        exp_long[b]    = run && !pr_h[ec-LP-1][b];
        exp_pressed[b] = stab_h[ec-1][b];
        exp_press[b]   = stab_h[ec-1][b] & ~stab_h[ec-2][b];
        exp_release[b] = ~stab_h[ec-1][b] & stab_h[ec-2][b];
      end
      pr_h[ec] = exp_pressed; rel_h[ec] = exp_release; long_h[ec] = exp_long;
    end
    model_ready = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ready)
      check_output("model", outs(),
                   {22'd0, exp_pressed, exp_press, exp_release, exp_long, exp_img});
  end

  typedef struct {
    logic [NB-1:0] btn_n;
    int            cycles;
    logic [NB-1:0] exp_pressed;
    logic [IW-1:0] exp_img;
  } step_t;

  step_t steps [11];

  task automatic apply_stimulus(input logic [NB-1:0] btn, input int cycles);
    bus.buttons_n = btn;
    repeat (cycles) @(negedge clk);
  endtask

  int lat;
  int cnt;
  int rst_left;
  int dur [NB];

  initial begin
    steps[0]  = '{2'b11, 10, 2'b00, 2'd0};
    steps[1]  = '{2'b01, 10, 2'b10, 2'd0};
    steps[2]  = '{2'b11, 10, 2'b00, 2'd1};
    steps[3]  = '{2'b01, 10, 2'b10, 2'd1};
    steps[4]  = '{2'b11, 10, 2'b00, 2'd2};
    steps[5]  = '{2'b01, 10, 2'b10, 2'd2};
    steps[6]  = '{2'b11, 10, 2'b00, 2'd0};
    steps[7]  = '{2'b01, 10, 2'b10, 2'd0};
    steps[8]  = '{2'b11, 10, 2'b00, 2'd1};
    steps[9]  = '{2'b00, 10, 2'b11, 2'd1};
    steps[10] = '{2'b11, 10, 2'b00, 2'd2};

    rst = 1'b1;
    bus.buttons_n = '1;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_hold", outs(), 32'(IR));
      bus.buttons_n = ~bus.buttons_n;
    end
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(2'b11, 8);
    check_output("post_reset", outs(), 32'(IR));

    // Button 0 press and release latency
    bus.buttons_n[0] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.pressed[0] && lat < 40);
    check_output("press_latency", lat - 1, DB + 2);
    check_output("press_pulse_on", bus.press_pulse[0], 1);
    @(negedge clk);
    check_output("press_pulse_off", {bus.pressed[0], bus.press_pulse[0]}, 2'b10);
    bus.buttons_n[0] = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (bus.pressed[0] && lat < 40);
    check_output("release_latency", lat - 1, DB + 2);
    check_output("release_pulse_on", bus.release_pulse[0], 1);
    apply_stimulus(2'b11, 5);

    for (int i = 0; i < 11; i++) begin
      apply_stimulus(steps[i].btn_n, steps[i].cycles);
      check_output($sformatf("table_pressed_%0d", i), bus.pressed, steps[i].exp_pressed);
      check_output($sformatf("table_img_%0d", i), bus.image_select, steps[i].exp_img);
    end

    // Glitches shorter than the debounce window
    cnt = 0;
    for (int g = 0; g < 10; g++) begin
      for (int c = 0; c < 6; c++) begin
        bus.buttons_n[1] = (c >= 3);
        @(negedge clk);
        if (bus.pressed[1] || bus.press_pulse[1] || bus.release_pulse[1]) cnt++;
      end
    end
    apply_stimulus(2'b11, 8);
    check_output("glitch_events", cnt, 0);
    check_output("glitch_img", bus.image_select, 2);

    // Long press from image 2, then 100 extra held cycles
    bus.buttons_n[1] = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.pressed[1] && lat < 40);
    check_output("long_press_seen", bus.pressed[1], 1);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.long_pulse[1] && lat < 60);
    check_output("long_latency", lat, LP);
    @(negedge clk);
    check_output("long_img", bus.image_select, 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.long_pulse[1]) cnt++;
    end
    check_output("long_repeat", cnt, 0);
    apply_stimulus(2'b11, 10);
    check_output("after_long_img", bus.image_select, 0);
    apply_stimulus(2'b01, 10);
    apply_stimulus(2'b11, 10);
    check_output("short_after_long_img", bus.image_select, 1);

    // Reset in the middle of a debounce with button 1 held through it
    bus.buttons_n[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("mid_reset", outs(), 32'(IR));
    rst = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!bus.press_pulse[1] && lat < 40);
    check_output("reset_redetect_latency", lat - 1, DB + 2);
    check_output("reset_redetect_img", bus.image_select, 0);
    apply_stimulus(2'b11, 10);
    check_output("redetect_release_img", bus.image_select, 1);

    // Long press and release landing on the same cycle
    apply_stimulus(2'b01, 20);
    apply_stimulus(2'b11, 7);
    check_output("coincide_pulses", {bus.long_pulse[1], bus.release_pulse[1]}, 2'b11);
    @(negedge clk);
    check_output("coincide_img", bus.image_select, 0);
    apply_stimulus(2'b11, 5);
    apply_stimulus(2'b01, 10);
    apply_stimulus(2'b11, 10);
    check_output("coincide_then_short_img", bus.image_select, 1);

    // Randomized pins with occasional resets, checked by the model
    rst_left = 0;
    for (int b = 0; b < NB; b++) dur[b] = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rst_left == 0 && $urandom_range(0, 499) == 0) rst_left = $urandom_range(1, 3);
      rst = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      for (int b = 0; b < NB; b++) begin
        if (dur[b] == 0) begin
          if ($urandom_range(0, 1) == 1) bus.buttons_n[b] = ~bus.buttons_n[b];
          dur[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 50) : $urandom_range(1, 8);
        end else begin
          dur[b]--;
        end
      end
      @(negedge clk);
    end
    rst = 1'b0;
    apply_stimulus(2'b11, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_buttons.md
# board_buttons

Parametrised front-panel input controller for the screensaver board wrappers. It synchronises and debounces N active-low push buttons and reports per-button level, press, release and long-press events. It also owns the image-select register, which the board wrapper feeds to `top`, so the image can be changed at run time. It sits between the raw board pins (An, Bn, …) and `top`, in the pixel clock domain.

## Interface

- `NUM_BUTTONS`, 2: number of active-low button inputs (≥1).
- `DEBOUNCE_CYCLES`, 251750: consecutive stable cycles required to accept a level change (≥1; ~10 ms at 25.175 MHz).
- `LONG_PRESS_CYCLES`, 25175000: held cycles before a long-press event (≥1; ~1 s).
- `NUM_IMAGES`, 4: number of selectable images (≥1).
- `SELECT_BUTTON`, 1: index of the button that drives image select (< NUM_BUTTONS).
- `IMAGE_RESET`, 0: image_select value after reset (< NUM_IMAGES).
- `clk_25_175`  in  1  pixel clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `buttons_n`  in  NUM_BUTTONS  raw asynchronous button pins, 0 = pressed.
- `pressed`  out  NUM_BUTTONS  debounced level, 1 = held.
- `press_pulse`  out  NUM_BUTTONS  one-cycle strobe when `pressed` rises.
- `release_pulse`  out  NUM_BUTTONS  one-cycle strobe when `pressed` falls.
- `long_pulse`  out  NUM_BUTTONS  one-cycle strobe when a hold reaches LONG_PRESS_CYCLES.
- `image_select`  out  IMG_W  current image index; IMG_W = max(1, $clog2(NUM_IMAGES)).

## Operation

- Per button, independently:
  - Synchronise through a 2-flop chain. Both flops reset to 1 (released).
  - Debounce counter:
    - Cleared whenever the synchronised level equals the stable state.
    - Otherwise increments.
    - On the cycle it would reach DEBOUNCE_CYCLES, the stable state flips and the counter clears.
    - A single-cycle glitch shorter than DEBOUNCE_CYCLES never changes `pressed`.
  - `press_pulse` / `release_pulse` are registered and asserted for exactly the cycle after the stable state changes, concurrent with the new `pressed` value.
  - Hold counter:
    - Counts cycles while `pressed`=1.
    - When it reaches LONG_PRESS_CYCLES, `long_pulse` fires once and the counter saturates (no auto-repeat).
    - Cleared when `pressed`=0.
  - A per-button `long_seen` flag is set by `long_pulse` and cleared on `release_pulse`.
- Image select state machine, SELECT_BUTTON only:
  - States: IDLE (released) → HELD (pressed, no long press) → LONG (long press fired) → IDLE.
  - IDLE→HELD on `press_pulse`.
  - HELD→LONG on `long_pulse`: `image_select` ← 0 on the same cycle.
  - HELD→IDLE on `release_pulse`: `image_select` ← `image_select`+1, wrapping NUM_IMAGES−1 → 0.
  - LONG→IDLE on `release_pulse`: no change to `image_select`.
  - NUM_IMAGES=1: `image_select` is constantly 0.
- Counter widths are sized from the parameters via $clog2; no counter ever wraps.
- Reset values:
  - `pressed`, `press_pulse`, `release_pulse`, `long_pulse` = 0.
  - `image_select` = IMAGE_RESET.
  - All counters 0; FSM in IDLE.
- Reset mid-operation discards any in-progress debounce, hold or FSM state.
- A button held through reset is re-detected after the full debounce time and produces a fresh `press_pulse`.

## Timing

- Latency from the first clock edge that samples a pin change to the `pressed` change is DEBOUNCE_CYCLES+2 cycles. `press_pulse` / `release_pulse` are asserted in that same cycle.
- `long_pulse` asserts LONG_PRESS_CYCLES cycles after `pressed` rises.
- `image_select` updates on the cycle after the qualifying pulse.
- Simultaneous events on different buttons are independent; there is no arbitration.
- If `long_pulse` and `release_pulse` coincide on the same button, the long press wins: image_select ← 0, and the FSM ends in IDLE.

## Test plan

Parameters: DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_IMAGES=3, IMAGE_RESET=0.

- Reset with all buttons released:
  - Required: all outputs 0, `image_select`=0.
  - Hold `rst` for 3 cycles while toggling `buttons_n`; outputs must stay at reset values.
- Drive `buttons_n[0]` low and hold:
  - `pressed[0]`=1 and `press_pulse[0]`=1 exactly 6 cycles later, for 1 cycle.
  - Release: `release_pulse[0]` 6 cycles after the release.
- Glitch: 3-cycle low pulses on `buttons_n[1]` repeated 10 times.
  - Required: no pulses, `pressed[1]` stays 0, `image_select` unchanged.
- Short presses of button 1 (10 cycles each):
  - `image_select` sequence 1, 2, 0, 1.
  - Each update lands on the cycle after `release_pulse[1]`.
- Long press on button 1 starting from `image_select`=2:
  - `long_pulse[1]` fires 20 cycles after `pressed[1]` rises, and `image_select`=0 on the next cycle.
  - After release, `image_select` is still 0.
  - Holding 100 more cycles before release gives no second `long_pulse`.
- Assert `rst` mid-debounce (cycle 2 of 4) with button 1 still held:
  - After reset, `image_select`=0.
  - `press_pulse[1]` appears DEBOUNCE_CYCLES+2 cycles after `rst` deasserts.
